sensor_spi_writer: RTL and testbench

SENSOR_SPI_WRITER -- requirements
Module: sensor_spi_writer

---
 rtl/sensor_pkg.sv | 31 +++
 rtl/sensor_spi_writer_sclk_tick_gen.sv | 36 +++
 rtl/sensor_spi_writer.sv | 169 ++++++++++++++++
 tb/tb_sensor_spi_writer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared sensor constants: frame geometry, writer FSM encoding, register map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sensor_pkg;

   localparam int FRAME_W = 24;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_CS_HOLD  = 3'd3,
      ST_GAP      = 3'd4
   } state_t;

   // Sensor register addresses shared with the sequencing controller.
   localparam logic [ADDR_W-1:0] SNS_REG_ID       = 7'h05;
   localparam logic [ADDR_W-1:0] SNS_REG_CTRL     = 7'h12;
   localparam logic [ADDR_W-1:0] SNS_REG_CFG      = 7'h20;
   localparam logic [ADDR_W-1:0] SNS_REG_SOFT_RST = 7'h7F;

   // Wire order of a frame: R/W flag, address, data (MSB first on the pin).
   function automatic logic [FRAME_W-1:0] pack_frame(input logic              rw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
      return {rw, addr, data};
   endfunction

endpackage

// File: rtl/sensor_spi_writer_sclk_tick_gen.sv
// SCLK phase tick: pulses on the last CLK of every CLK_DIV-cycle phase.
// Latency: tick is combinational from the count; first tick CLK_DIV cycles after enable.
// Backpressure: none; counter holds while disabled and is zeroed by clr_i.
module sclk_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   // Wrap at LAST while enabled; a frame start forces a clean phase alignment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
      end
   end

   // Phase counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sensor_spi_writer.sv
// SPI mode-0 master issuing one 24-bit {rw, addr, data} frame per command.
// Latency: default timing holds CS_N low T+1..T+196, done at T+201 after acceptance at T.
// Backpressure: cmd_ready only in IDLE; next command may be taken in the done cycle.
module sensor_spi_writer
   import sensor_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int CS_SETUP_CYC = 2,
   parameter int CS_HOLD_CYC  = 2,
   parameter int GAP_CYC      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              spi_cs_n,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYC - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CYC - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
   localparam logic [4:0] LAST_BIT   = 5'(FRAME_W - 1);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [4:0]          bit_q, bit_d;
   logic [FRAME_W-1:0]  sh_q, sh_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   rd_q, rd_d;
   logic                rw_q, rw_d;
   logic                cs_n_q, cs_n_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic                done_q, done_d;
   logic                accept;
   logic                tick;

   // Ready is masked by reset so nothing can be taken while reset is held.
   assign cmd_ready = (state_q == ST_IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q != ST_IDLE);

   sclk_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (accept),
      .en_i   (state_q == ST_SHIFT),
      .tick_o (tick)
   );

   // Next-state and registered-output logic for the frame sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               sh_d    = pack_frame(cmd_rw, cmd_addr, cmd_data);
               rw_d    = cmd_rw;
               mosi_d  = sh_d[FRAME_W-1];
               cs_n_d  = 1'b0;
               cnt_d   = SETUP_LAST;
               bit_d   = '0;
               state_d = ST_CS_SETUP;
            end
         end
         ST_CS_SETUP: begin
            if (cnt_q == 8'd0) state_d = ST_SHIFT;
            else               cnt_d   = cnt_q - 8'd1;
         end
         ST_SHIFT: begin
            if (tick) begin
               if (!sclk_q) begin
                  // Rising edge: sample MISO with the edge the slave expects.
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[DATA_W-2:0], spi_miso};
               end else begin
                  // Falling edge: next bit goes out, or the frame ends.
                  sclk_d = 1'b0;
                  if (bit_q == LAST_BIT) begin
                     mosi_d  = 1'b0;
                     cnt_d   = HOLD_LAST;
                     state_d = ST_CS_HOLD;
                  end else begin
                     bit_d  = bit_q + 5'd1;
                     sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
                     mosi_d = sh_q[FRAME_W-2];
                  end
               end
            end
         end
         ST_CS_HOLD: begin
            if (cnt_q == 8'd0) begin
               cs_n_d  = 1'b1;
               cnt_d   = GAP_LAST;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               if (rw_q) rd_d = rx_q;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and pin registers; reset drops any frame in flight at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         rx_q    <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
      end
   end

   assign spi_cs_n = cs_n_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign done     = done_q;
   assign rd_data  = rd_q;

endmodule

// File: tb/tb_sensor_spi_writer.sv
// Scoreboard bench for sensor_spi_writer: default instance plus a CLK_DIV=1 instance.
// Latency: frame timing measured from the acceptance cycle against values derived from parameters.
// Backpressure: commands are held until cmd_ready; ignored offers must not create frames.
module tb_sensor_spi_writer;
   import sensor_pkg::*;

   localparam int NDUT  = 2;
   localparam int DIV0  = 4;
   localparam int DIV1  = 1;
   localparam int SETUP = 2;
   localparam int HOLD  = 2;
   localparam int GAP   = 4;

   typedef struct {
      int          idx;
      logic        rw;
      logic [23:0] frame;
      logic [15:0] rd;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [NDUT-1:0] cmd_valid;
   logic            cmd_rw;
   logic [6:0]      cmd_addr;
   logic [15:0]     cmd_data;
   logic [NDUT-1:0] cmd_ready, busy, done, cs_n, sclk, mosi, miso;
   logic [15:0]     rd_data [NDUT];

   sensor_spi_writer #(.CLK_DIV(DIV0), .CS_SETUP_CYC(SETUP), .CS_HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy[0]), .done(done[0]),
      .rd_data(rd_data[0]), .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));

   sensor_spi_writer #(.CLK_DIV(DIV1), .CS_SETUP_CYC(SETUP), .CS_HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut_div1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy[1]), .done(done[1]),
      .rd_data(rd_data[1]), .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));

   int n_checks = 0;
   int n_errors = 0;
   exp_t exp_q[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-DUT monitor state
   int          t_acc [NDUT], fall_cyc [NDUT], cs_rise_cyc [NDUT], gap_len [NDUT];
   int          acc_after_done [NDUT], last_done_cyc [NDUT], acc_cnt [NDUT];
   int          rises [NDUT], first_rise [NDUT], prev_rise [NDUT], last_per [NDUT];
   int          low_cnt [NDUT], inv_bad [NDUT];
   logic [23:0] mosi_bits [NDUT];
   logic [23:0] miso_pat [NDUT];
   logic [15:0] rd_model [NDUT];
   logic        prev_sclk [NDUT], prev_cs_n [NDUT];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int div_of(input int i);
      return (i == 0) ? DIV0 : DIV1;
   endfunction

   function automatic int exp_low(input int i);
      return SETUP + 24 * 2 * div_of(i) + HOLD;
   endfunction

   function automatic int exp_done(input int i);
      return 1 + exp_low(i) + GAP;
   endfunction

   // Passive monitor, SPI slave model and scoreboard compare; samples on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < NDUT; i++) begin
         if (reset) begin
            rises[i] = 0; mosi_bits[i] = '0; prev_sclk[i] = 1'b0; prev_cs_n[i] = 1'b1;
            low_cnt[i] = 0; inv_bad[i] = 0; rd_model[i] = '0; cs_rise_cyc[i] = -1;
            last_done_cyc[i] = -1000; first_rise[i] = 0; prev_rise[i] = 0; last_per[i] = 0;
            miso[i] = 1'b0;
         end else begin
            if (busy[i] !== !cmd_ready[i]) inv_bad[i]++;
            if (cs_n[i] && sclk[i])        inv_bad[i]++;
            if (!cs_n[i] && cmd_ready[i])  inv_bad[i]++;
            if (done[i] && !cmd_ready[i])  inv_bad[i]++;
            if (!cs_n[i] && prev_cs_n[i]) begin
               fall_cyc[i] = cyc; low_cnt[i] = 0; rises[i] = 0; mosi_bits[i] = '0;
               gap_len[i] = (cs_rise_cyc[i] >= 0) ? cyc - cs_rise_cyc[i] : -1;
            end
            if (!cs_n[i]) low_cnt[i]++;
            if (cs_n[i] && !prev_cs_n[i]) cs_rise_cyc[i] = cyc;
            if (sclk[i] && !prev_sclk[i]) begin
               mosi_bits[i] = {mosi_bits[i][22:0], mosi[i]};
               if (rises[i] == 0) first_rise[i] = cyc;
               else               last_per[i]   = cyc - prev_rise[i];
               prev_rise[i] = cyc;
               rises[i]++;
            end
            prev_sclk[i] = sclk[i];
            prev_cs_n[i] = cs_n[i];
            // Mode-0 slave: present bit k of the pattern before the k-th rising edge.
            miso[i] = (!cs_n[i] && rises[i] < 24) ? miso_pat[i][23 - rises[i]] : 1'b0;
            if (done[i]) begin
               if (exp_q.size() == 0) begin
                  chk("done_unexpected", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_dut",       32'(i), 32'(e.idx));
                  chk("mosi_frame",     32'(mosi_bits[i]), 32'(e.frame));
                  chk("sclk_rises",     32'(rises[i]), 32'd24);
                  chk("cs_fall_ofs",    32'(fall_cyc[i] - t_acc[i]), 32'd1);
                  chk("cs_low_len",     32'(low_cnt[i]), 32'(exp_low(i)));
                  chk("first_rise_ofs", 32'(first_rise[i] - t_acc[i]), 32'(1 + SETUP + div_of(i)));
                  chk("sclk_period",    32'(last_per[i]), 32'(2 * div_of(i)));
                  chk("done_ofs",       32'(cyc - t_acc[i]), 32'(exp_done(i)));
                  if (e.rw) rd_model[i] = e.rd;
                  chk("rd_data",        32'(rd_data[i]), 32'(rd_model[i]));
                  chk("invariants",     32'(inv_bad[i]), 32'd0);
               end
               last_done_cyc[i] = cyc;
            end
            if (cmd_valid[i] && cmd_ready[i]) begin
               t_acc[i] = cyc;
               acc_after_done[i] = cyc - last_done_cyc[i];
               acc_cnt[i]++;
            end
         end
      end
   end

   task automatic wait_ready(input int i);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready[i] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready[i]) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int i);
      int n = 0;
      @(negedge clk);
      while (!done[i] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!done[i]) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic push_exp(input int i, input logic rw, input logic [6:0] a, input logic [15:0] d,
                           input logic [23:0] pat);
      exp_t e;
      e.idx = i; e.rw = rw; e.frame = {rw, a, d}; e.rd = pat[15:0];
      exp_q.push_back(e);
   endtask

   task automatic send(input int i, input logic rw, input logic [6:0] a, input logic [15:0] d,
                       input logic [23:0] pat);
      @(posedge clk); #2;
      cmd_rw = rw; cmd_addr = a; cmd_data = d; miso_pat[i] = pat; cmd_valid[i] = 1'b1;
      push_exp(i, rw, a, d, pat);
      wait_ready(i);
      @(posedge clk); #2;
      cmd_valid[i] = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int n;
      int acc_before;
      int dn;
      reset = 1'b1; cmd_valid = '0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
      for (int i = 0; i < NDUT; i++) begin
         miso_pat[i] = '0; acc_cnt[i] = 0; t_acc[i] = 0; gap_len[i] = -1; acc_after_done[i] = -1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         chk("rst_cs_n",  32'(cs_n[i]), 32'd1);
         chk("rst_sclk",  32'(sclk[i]), 32'd0);
         chk("rst_mosi",  32'(mosi[i]), 32'd0);
         chk("rst_done",  32'(done[i]), 32'd0);
         chk("rst_busy",  32'(busy[i]), 32'd0);
         chk("rst_ready", 32'(cmd_ready[i]), 32'd0);
         chk("rst_rd",    32'(rd_data[i]), 32'd0);
      end
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(cmd_ready[0]), 32'd1);
      chk("busy_after_rst",  32'(busy[0]), 32'd0);

      // Plain write
      send(0, 1'b0, SNS_REG_CTRL, 16'hA5C3, 24'h000000);
      wait_done(0);

      // Read: upper pattern byte must not leak into rd_data
      send(0, 1'b1, SNS_REG_ID, 16'h0000, 24'h5ABEEF);
      wait_done(0);

      // Write while MISO toggles: rd_data keeps the last read value
      send(0, 1'b0, SNS_REG_CFG, 16'h0F0F, 24'hFFFFFF);
      wait_done(0);

      // Back-to-back with cmd_valid held across both frames
      @(posedge clk); #2;
      miso_pat[0] = '0;
      push_exp(0, 1'b0, 7'h21, 16'h1357, 24'h0);
      push_exp(0, 1'b0, 7'h22, 16'h2468, 24'h0);
      cmd_rw = 1'b0; cmd_addr = 7'h21; cmd_data = 16'h1357; cmd_valid[0] = 1'b1;
      wait_ready(0);
      @(posedge clk); #2;
      cmd_addr = 7'h22; cmd_data = 16'h2468;
      wait_ready(0);
      @(posedge clk); #2;
      cmd_valid[0] = 1'b0;
      wait_done(0);
      chk("b2b_accept_in_done", 32'(acc_after_done[0]), 32'd0);
      // CS_N high spans the GAP cycles plus the done/accept cycle.
      chk("b2b_cs_high", 32'(gap_len[0]), 32'(GAP + 1));

      // Offers made mid-frame must be ignored
      send(0, 1'b0, 7'h30, 16'hC0DE, 24'h0);
      n = 0;
      while (rises[0] < 3 && n < 500) begin
         @(posedge clk);
         n++;
      end
      acc_before = acc_cnt[0];
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #2;
         cmd_valid[0] = ~cmd_valid[0];
         cmd_rw = 1'($urandom); cmd_addr = 7'($urandom); cmd_data = 16'($urandom);
      end
      @(posedge clk); #2;
      cmd_valid[0] = 1'b0;
      chk("busy_no_accept", 32'(acc_cnt[0] - acc_before), 32'd0);
      wait_done(0);

      // Reset during bit 10 of a read frame
      send(0, 1'b1, 7'h07, 16'h0000, 24'hC3A55A);
      n = 0;
      while (rises[0] < 10 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #2 reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
      chk("abort_sclk", 32'(sclk[0]), 32'd0);
      chk("abort_done", 32'(done[0]), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_rd",   32'(rd_data[0]), 32'd0);
      @(posedge clk); #2 reset = 1'b0;
      dn = 0;
      for (int k = 0; k < 210; k++) begin
         @(negedge clk);
         if (done[0]) dn++;
      end
      chk("abort_no_done", 32'(dn), 32'd0);
      send(0, 1'b0, SNS_REG_CTRL, 16'h5555, 24'h0);
      wait_done(0);

      // Fastest SCLK on the second instance
      send(1, 1'b0, SNS_REG_SOFT_RST, 16'hFFFF, 24'h0);
      wait_done(1);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
